// File: rtl/sm_arith_arbiter.sv
// -----------------------------------------------------------------------------
// sm_arith_arbiter
//
// Purpose:
//   Two requesters share one external sign-magnitude subtractor. A round-robin
//   arbiter picks one pending operation, a three-state FSM (IDLE -> CALC ->
//   RESP) drives the operands to the subtractor for exactly one cycle, captures
//   its result and carry, and holds the response until the consumer takes it.
//   Only one operation is ever in flight.
//
//   Operations: op = 0 computes A - B, op = 1 computes A + B. Addition reuses
//   the subtractor by flipping the sign bit of B, since A + B == A - (-B).
//
// Configuration:
//   SM_NEG_ZERO_FIX_EN  defined   : a captured result with zero magnitude has
//                                   its sign bit forced to 0 (no negative zero);
//                                   the carry flag is not affected.
//                       undefined : the captured result is passed through
//                                   bit-for-bit, negative zero included.
//
// Ports:
//   in_clk, in_rst_n                  clock, async active-low reset
//   in_reqK_valid / o_reqK_ready      requester K handshake (K = 0, 1);
//                                     ready is combinational, IDLE only
//   in_reqK_a, in_reqK_b, in_reqK_op  requester K operands and operation
//   o_sub_a, o_sub_b                  operands to the shared subtractor
//                                     (non-zero only in CALC)
//   in_sub_out, in_sub_carry          shared subtractor result and overflow
//   o_rsp_valid / in_rsp_ready        response handshake
//   o_rsp_id, o_rsp_out, o_rsp_carry  response owner, result, overflow flag
// -----------------------------------------------------------------------------
module sm_arith_arbiter #(
  parameter int N = 8
) (
  input  logic         in_clk,
  input  logic         in_rst_n,

  input  logic         in_req0_valid,
  input  logic         in_req1_valid,
  output logic         o_req0_ready,
  output logic         o_req1_ready,
  input  logic [N-1:0] in_req0_a,
  input  logic [N-1:0] in_req0_b,
  input  logic [N-1:0] in_req1_a,
  input  logic [N-1:0] in_req1_b,
  input  logic         in_req0_op,
  input  logic         in_req1_op,

  output logic [N-1:0] o_sub_a,
  output logic [N-1:0] o_sub_b,
  input  logic [N-1:0] in_sub_out,
  input  logic         in_sub_carry,

  output logic         o_rsp_valid,
  input  logic         in_rsp_ready,
  output logic         o_rsp_id,
  output logic [N-1:0] o_rsp_out,
  output logic         o_rsp_carry
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic           last_q,  last_d;    // requester granted most recently
  logic [N-1:0]   a_q,     a_d;       // latched operand A
  logic [N-1:0]   b_q,     b_d;       // latched operand B (as presented)
  logic           op_q,    op_d;      // latched operation
  logic           id_q,    id_d;      // owner of the in-flight operation
  logic [N-1:0]   out_q,   out_d;     // captured result
  logic           carry_q, carry_d;   // captured overflow

  // Arbitration outcome for the current cycle (meaningful only in IDLE).
  logic           grant_valid;
  logic           grant_id;

  // Captured result after the optional negative-zero clean-up.
  logic [N-1:0]   sub_out_fixed;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  // A lone requester always wins. On a tie the requester that was not granted
  // last wins; the pointer resets to "req1 last" so req0 wins the first tie.
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (in_req0_valid && in_req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_q;
    end else if (in_req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (in_req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Negative-zero handling of the subtractor result
  // ---------------------------------------------------------------------------
`ifdef SM_NEG_ZERO_FIX_EN
  always_comb begin
    sub_out_fixed = in_sub_out;
    if (in_sub_out[N-2:0] == '0) begin
      sub_out_fixed[N-1] = 1'b0;
    end
  end
`else
  assign sub_out_fixed = in_sub_out;
`endif

  // ---------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the latched operands are reset as well, so a discarded operation
  // leaves nothing behind that could reach the subtractor after reset.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state and register inputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    out_d   = out_q;
    carry_d = carry_q;

    unique case (state_q)
      ST_IDLE: begin
        // The pointer moves only on an actual grant, never on idle cycles.
        if (grant_valid) begin
          state_d = ST_CALC;
          last_d  = grant_id;
          id_d    = grant_id;
          if (grant_id) begin
            a_d  = in_req1_a;
            b_d  = in_req1_b;
            op_d = in_req1_op;
          end else begin
            a_d  = in_req0_a;
            b_d  = in_req0_b;
            op_d = in_req0_op;
          end
        end
      end

      ST_CALC: begin
        // The subtractor is combinational outside this block; its result is
        // valid for the whole CALC cycle and is captured on the closing edge.
        state_d = ST_RESP;
        out_d   = sub_out_fixed;
        carry_d = in_sub_carry;
      end

      ST_RESP: begin
        if (in_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_sub_a      = '0;
    o_sub_b      = '0;
    o_rsp_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Ready is combinational from valid; it is also held low while reset
        // is asserted so nothing looks accepted during reset.
        o_req0_ready = in_rst_n && grant_valid && !grant_id;
        o_req1_ready = in_rst_n && grant_valid &&  grant_id;
      end

      ST_CALC: begin
        o_sub_a = a_q;
        o_sub_b = (op_q == OP_SUB) ? b_q : {~b_q[N-1], b_q[N-2:0]};
      end

      ST_RESP: begin
        o_rsp_valid = 1'b1;
      end

      default: begin
        o_rsp_valid = 1'b0;
      end
    endcase
  end

  // Response payload comes straight from registers, so it is stable for the
  // whole RESP period regardless of what the requesters do.
  assign o_rsp_id    = id_q;
  assign o_rsp_out   = out_q;
  assign o_rsp_carry = carry_q;

endmodule

// File: tb/tb_sm_arith_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sm_arith_arbiter
//
// Self-checking bench for sm_arith_arbiter (N = 8). Models the shared
// sign-magnitude subtractor combinationally, applies a table of single
// operations, and runs hand-written sequences for alternation, back-pressure
// and reset-in-flight. A monitor pushes expected responses on every grant and
// pops/compares them when a response is taken.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sm_arith_arbiter;

  localparam int N = 8;

`ifdef SM_NEG_ZERO_FIX_EN
  localparam logic [N-1:0] NEG_ZERO_OUT = 8'h00;
`else
  localparam logic [N-1:0] NEG_ZERO_OUT = 8'h80;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req0_valid, in_req1_valid;
  logic         o_req0_ready, o_req1_ready;
  logic [N-1:0] in_req0_a, in_req0_b, in_req1_a, in_req1_b;
  logic         in_req0_op, in_req1_op;
  logic [N-1:0] o_sub_a, o_sub_b;
  logic [N-1:0] in_sub_out;
  logic         in_sub_carry;
  logic         o_rsp_valid;
  logic         in_rsp_ready;
  logic         o_rsp_id;
  logic [N-1:0] o_rsp_out;
  logic         o_rsp_carry;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sm_arith_arbiter #(.N(N)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_req0_valid (in_req0_valid),
    .in_req1_valid (in_req1_valid),
    .o_req0_ready  (o_req0_ready),
    .o_req1_ready  (o_req1_ready),
    .in_req0_a     (in_req0_a),
    .in_req0_b     (in_req0_b),
    .in_req1_a     (in_req1_a),
    .in_req1_b     (in_req1_b),
    .in_req0_op    (in_req0_op),
    .in_req1_op    (in_req1_op),
    .o_sub_a       (o_sub_a),
    .o_sub_b       (o_sub_b),
    .in_sub_out    (in_sub_out),
    .in_sub_carry  (in_sub_carry),
    .o_rsp_valid   (o_rsp_valid),
    .in_rsp_ready  (in_rsp_ready),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_out     (o_rsp_out),
    .o_rsp_carry   (o_rsp_carry)
  );

  // ---------------------------------------------------------------------------
  // Shared subtractor model: returns {carry, result} of a - b, sign-magnitude.
  // Equal magnitudes with opposite effective signs keep the sign of a.
  // ---------------------------------------------------------------------------
  function automatic logic [N:0] sub_model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic         sa, sb;
    logic [N-1:0] ma, mb, m;
    sa = a[N-1];
    sb = ~b[N-1];
    ma = {1'b0, a[N-2:0]};
    mb = {1'b0, b[N-2:0]};
    if (sa == sb) begin
      m = ma + mb;
      return {m[N-1], sa, m[N-2:0]};
    end else if (ma >= mb) begin
      m = ma - mb;
      return {1'b0, sa, m[N-2:0]};
    end else begin
      m = mb - ma;
      return {1'b0, sb, m[N-2:0]};
    end
  endfunction

  logic [N:0] sub_res;
  always_comb sub_res = sub_model(o_sub_a, o_sub_b);
  assign in_sub_out   = sub_res[N-1:0];
  assign in_sub_carry = sub_res[N];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic         id;
    logic [N-1:0] out;
    logic         carry;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t sb_exp;

  function automatic rsp_t expect_rsp(input logic id, input logic [N-1:0] a,
                                      input logic [N-1:0] b, input logic op);
    rsp_t         r;
    logic [N-1:0] bb;
    logic [N:0]   s;
    bb = op ? {~b[N-1], b[N-2:0]} : b;
    s  = sub_model(a, bb);
    r.id    = id;
    r.out   = s[N-1:0];
    r.carry = s[N];
`ifdef SM_NEG_ZERO_FIX_EN
    if (r.out[N-2:0] == '0) r.out[N-1] = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_req0_ready) sb_q.push_back(expect_rsp(1'b0, in_req0_a, in_req0_b, in_req0_op));
      if (o_req1_ready) sb_q.push_back(expect_rsp(1'b1, in_req1_a, in_req1_b, in_req1_op));
      if (o_rsp_valid && in_rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'(o_rsp_valid), 32'd0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_id",    32'(o_rsp_id),    32'(sb_exp.id));
          check("sb_out",   32'(o_rsp_out),   32'(sb_exp.out));
          check("sb_carry", 32'(o_rsp_carry), 32'(sb_exp.carry));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         v0;
    logic         v1;
    logic [N-1:0] a0, b0;
    logic         op0;
    logic [N-1:0] a1, b1;
    logic         op1;
    logic         gid;
    logic [N-1:0] sub_a, sub_b, out;
    logic         carry;
  } vec_t;

  localparam int NV = 8;
  vec_t vec[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_req0_valid = 1'b0; in_req1_valid = 1'b0;
    in_req0_a = '0; in_req0_b = '0; in_req0_op = 1'b0;
    in_req1_a = '0; in_req1_b = '0; in_req1_op = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {3'b0, o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id,
                 o_rsp_out, o_rsp_carry, o_sub_a, o_sub_b}, 32'd0);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic exp_id;

    vec[0] = '{1'b1, 1'b0, 8'h05, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h05, 8'h03, 8'h02, 1'b0};
    vec[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h64, 8'h64, 1'b1, 1'b1, 8'h64, 8'hE4, 8'h48, 1'b1};
    vec[2] = '{1'b1, 1'b0, 8'h83, 8'h83, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h83, 8'h83, NEG_ZERO_OUT, 1'b0};
    vec[3] = '{1'b1, 1'b1, 8'h10, 8'h01, 1'b1, 8'h02, 8'h07, 1'b0, 1'b1, 8'h02, 8'h07, 8'h85, 1'b0};
    vec[4] = '{1'b1, 1'b1, 8'h10, 8'h01, 1'b1, 8'h02, 8'h07, 1'b0, 1'b0, 8'h10, 8'h81, 8'h11, 1'b0};
    vec[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h85, 8'h02, 1'b1, 1'b1, 8'h85, 8'h82, 8'h83, 1'b0};
    vec[6] = '{1'b1, 1'b0, 8'h7F, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h7F, 8'hFF, 8'h7E, 1'b1};
    vec[7] = '{1'b1, 1'b0, 8'h03, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h03, 8'h08, 8'h85, 1'b0};

    // ---------------- Reset state ----------------
    rst_n = 1'b0;
    in_rsp_ready = 1'b1;
    idle_inputs();
    #1;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs_held");
    rst_n = 1'b1;

    // ---------------- Table-driven single operations ----------------
    for (int i = 0; i < NV; i++) begin
      in_req0_valid = vec[i].v0; in_req0_a = vec[i].a0; in_req0_b = vec[i].b0; in_req0_op = vec[i].op0;
      in_req1_valid = vec[i].v1; in_req1_a = vec[i].a1; in_req1_b = vec[i].b1; in_req1_op = vec[i].op1;
      in_rsp_ready  = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_grant", i), {o_req0_ready, o_req1_ready},
            vec[i].gid ? 32'd1 : 32'd2);
      tick();                                   // acceptance edge
      idle_inputs();
      @(negedge clk);                           // CALC
      check($sformatf("v%0d_sub_a", i), o_sub_a, vec[i].sub_a);
      check($sformatf("v%0d_sub_b", i), o_sub_b, vec[i].sub_b);
      check($sformatf("v%0d_calc_quiet", i), {o_req0_ready, o_req1_ready, o_rsp_valid}, 32'd0);
      tick();
      @(negedge clk);                           // RESP, two edges after acceptance
      check($sformatf("v%0d_rsp_valid", i), o_rsp_valid, 32'd1);
      check($sformatf("v%0d_rsp_id", i),    o_rsp_id,    vec[i].gid);
      check($sformatf("v%0d_rsp_out", i),   o_rsp_out,   vec[i].out);
      check($sformatf("v%0d_rsp_carry", i), o_rsp_carry, vec[i].carry);
      tick();
      @(negedge clk);                           // back in IDLE
      check($sformatf("v%0d_idle", i), {o_rsp_valid, o_sub_a, o_sub_b}, 32'd0);
      tick();
    end

    // ---------------- Both valid continuously: alternation ----------------
    rst_n = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    in_req0_valid = 1'b1; in_req0_a = 8'h05; in_req0_b = 8'h03; in_req0_op = 1'b0;
    in_req1_valid = 1'b1; in_req1_a = 8'h64; in_req1_b = 8'h64; in_req1_op = 1'b1;
    in_rsp_ready  = 1'b1;
    got    = 0;
    exp_id = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) check("first_grant_after_reset", {o_req0_ready, o_req1_ready}, 32'd2);
      check("ready_exclusive", o_req0_ready & o_req1_ready, 32'd0);
      if (o_rsp_valid) begin
        check($sformatf("alt_id_%0d", got), o_rsp_id, exp_id);
        exp_id = ~exp_id;
        got++;
      end
      if (got == 4) break;
      tick();
    end
    check("alt_rsp_count", got, 32'd4);
    tick();
    idle_inputs();

    // ---------------- Back-pressure in RESP ----------------
    in_rsp_ready  = 1'b0;
    in_req0_valid = 1'b1; in_req0_a = 8'h83; in_req0_b = 8'h83; in_req0_op = 1'b0;
    @(negedge clk);
    check("bp_grant", {o_req0_ready, o_req1_ready}, 32'd2);
    tick();
    idle_inputs();
    in_req1_valid = 1'b1; in_req1_a = 8'h85; in_req1_b = 8'h02; in_req1_op = 1'b1;
    @(negedge clk);
    check("bp_calc_no_ready", {o_req0_ready, o_req1_ready}, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_%0d", k),
            {o_rsp_valid, o_rsp_id, o_rsp_out, o_rsp_carry, o_req0_ready, o_req1_ready},
            {20'd0, 1'b1, 1'b0, NEG_ZERO_OUT, 1'b0, 2'b00});
      tick();
    end
    in_rsp_ready = 1'b1;                        // completion on the 6th cycle
    @(negedge clk);
    check("bp_complete_valid", o_rsp_valid, 32'd1);
    tick();
    @(negedge clk);
    check("bp_back_idle", o_rsp_valid, 32'd0);
    check("bp_waiting_req1_granted", {o_req0_ready, o_req1_ready}, 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    tick();
    @(negedge clk);
    check("bp_req1_out", {o_rsp_valid, o_rsp_id, o_rsp_out}, {22'd0, 1'b1, 1'b1, 8'h83});
    tick();

    // ---------------- Reset during CALC ----------------
    in_req0_valid = 1'b1; in_req0_a = 8'h7F; in_req0_b = 8'h01; in_req0_op = 1'b0;
    @(negedge clk);
    check("rst_pre_grant", {o_req0_ready, o_req1_ready}, 32'd2);
    tick();
    idle_inputs();
    @(negedge clk);                             // CALC
    check("rst_pre_calc_sub_a", o_sub_a, 8'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_calc_outputs");
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_rsp_%0d", k), o_rsp_valid, 32'd0);
      tick();
    end
    in_req0_valid = 1'b1; in_req0_a = 8'h10; in_req0_b = 8'h01; in_req0_op = 1'b1;
    in_req1_valid = 1'b1; in_req1_a = 8'h02; in_req1_b = 8'h07; in_req1_op = 1'b0;
    @(negedge clk);
    check("rst_post_req0_priority", {o_req0_ready, o_req1_ready}, 32'd2);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rst_post_sub_b", o_sub_b, 8'h81);
    tick();
    @(negedge clk);
    check("rst_post_rsp", {o_rsp_valid, o_rsp_id, o_rsp_out, o_rsp_carry},
          {21'd0, 1'b1, 1'b0, 8'h11, 1'b0});
    tick();
    @(negedge clk);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_arith_arbiter.md
SM_ARITH_ARBITER -- requirements
Module: sm_arith_arbiter

Interface
REQ-001 Parameter: N, default 8, operand/result width; sign-magnitude format, bit N-1 = sign, bits N-2:0 = magnitude.
REQ-002 in_clk  input  1  single clock; all state updates on rising edge.
REQ-003 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_req0_valid / in_req1_valid  input  1  requester k holds an operation.
REQ-005 o_req0_ready / o_req1_ready  output  1  requester k operation accepted this cycle.
REQ-006 in_req0_a, in_req0_b, in_req1_a, in_req1_b  input  N  operands.
REQ-007 in_req0_op / in_req1_op  input  1  0 = A-B, 1 = A+B.
REQ-008 o_sub_a, o_sub_b  output  N  operands driven to the shared sign-magnitude subtractor.
REQ-009 in_sub_out  input  N  shared subtractor result.
REQ-010 in_sub_carry  input  1  shared subtractor magnitude overflow.
REQ-011 o_rsp_valid  output  1  response available.
REQ-012 in_rsp_ready  input  1  consumer takes the response.
REQ-013 o_rsp_id  output  1  index of the requester that owns the response.
REQ-014 o_rsp_out  output  N  result; o_rsp_carry  output  1  overflow flag.

Function
REQ-015 FSM states IDLE, CALC, RESP; reset state IDLE.
REQ-016 IDLE: if any valid, grant one; o_reqk_ready = 1 (combinational) only for the granted k, only in IDLE; on that edge latch a, b, op, id; go CALC.
REQ-017 Arbitration round-robin: single valid wins; both valid -> grant the requester not granted last; after reset req0 wins first tie.
REQ-018 CALC (exactly one cycle): o_sub_a = latched a; o_sub_b = latched b for op 0, latched b with bit N-1 inverted for op 1; capture in_sub_out and in_sub_carry at end of cycle; go RESP.
REQ-019 Outside CALC, o_sub_a and o_sub_b hold 0.
REQ-020 RESP: o_rsp_valid = 1 with o_rsp_id/out/carry stable; on in_rsp_ready = 1 go IDLE, else hold indefinitely.
REQ-021 Latency: acceptance edge t -> o_rsp_valid high from cycle t+2 (after two edges); one operation in flight, throughput one op per 3 cycles minimum.
REQ-022 No ready asserted in CALC or RESP; requests presented there wait, their operands are not sampled.
REQ-023 Requester dropping valid before being granted loses nothing and changes no state.
REQ-024 Arbiter pointer updates only on a grant, never on idle cycles.

Reset
REQ-025 in_rst_n low: immediately force IDLE, pointer = req1-last (req0 priority), o_rsp_valid = 0, o_req0_ready = o_req1_ready = 0, o_rsp_id = 0, o_rsp_out = 0, o_rsp_carry = 0, o_sub_a = o_sub_b = 0, latched operands = 0.
REQ-026 Reset asserted in CALC or RESP discards the in-flight operation; no response is produced for it after release.
REQ-027 First grant possible in the first cycle after in_rst_n deasserts.

Configuration
REQ-028 Macro SM_NEG_ZERO_FIX_EN defined: when captured magnitude (bits N-2:0) is 0, o_rsp_out sign bit forced 0 (no negative zero); carry unaffected.
REQ-029 Macro undefined: o_rsp_out equals captured in_sub_out bit-for-bit, negative zero passed through.

Verification (N = 8, bench models shared subtractor)
REQ-030 req0 a=0x05 b=0x03 op=0 -> o_sub_a=0x05, o_sub_b=0x03 in CALC; response id=0, out=0x02, carry=0, valid at t+2.
REQ-031 req1 a=0x64 b=0x64 op=1 -> o_sub_b=0xE4; response id=1, out=0x48, carry=1.
REQ-032 req0 a=0x83 b=0x83 op=0 -> out=0x80 without SM_NEG_ZERO_FIX_EN, out=0x00 with it; carry=0.
REQ-033 Both valid continuously after reset, in_rsp_ready=1 -> responses alternate id 0,1,0,1; readies never both high.
REQ-034 in_rsp_ready held 0 for 5 cycles in RESP -> o_rsp_valid and data stable, no ready asserted; completion on 6th cycle, then IDLE.
REQ-035 in_rst_n pulsed low during CALC -> all outputs 0 immediately, no response afterwards; next request served normally with req0 priority.
